// File: rtl/fsm_encoder_engine.sv
// Rate-1/2 layered encoder sequencer. It loads the info sub-blocks, steps the
// parity datapath through its layers, then streams out the codeword sub-blocks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_LOAD   | accept info sub-blocks into the info buffer (col_q = load count)
//   ST_PARITY | step layer_q/cyc_q over NUM_LAYERS*LAYER_CYCLES cycles
//   ST_OUTPUT | present codeword sub-blocks (col_q = output count)
module fsm_encoder_engine #(
  parameter int NUM_LAYERS    = 8,
  parameter int NUM_INFO_COLS = 8,
  parameter int NUM_CODE_COLS = 16,
  parameter int LAYER_CYCLES  = 4,
  parameter int WIDTH_RATE    = 2,
  parameter logic [WIDTH_RATE-1:0] RATE_1_2 = '0,
  // Column index must cover both the info and the codeword sub-block ranges.
  parameter int WIDTH_COL =
    (((NUM_CODE_COLS > NUM_INFO_COLS) ? NUM_CODE_COLS : NUM_INFO_COLS) > 1) ?
    $clog2((NUM_CODE_COLS > NUM_INFO_COLS) ? NUM_CODE_COLS : NUM_INFO_COLS) : 1,
  parameter int WIDTH_LAYER = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_RATE-1:0]  rate,
  input  logic                   validIn,
  input  logic                   lastIn,
  output logic                   readyIn,
  output logic                   InfoWrEn,
  output logic [WIDTH_COL-1:0]   CurrCol,
  output logic [WIDTH_LAYER-1:0] CurrLayer,
  output logic                   ParityAccValid,
  output logic                   validOut,
  output logic                   lastOut,
  input  logic                   readyOut,
  output logic                   busy,
  output logic                   errLast
);

  localparam int WIDTH_CYC = (LAYER_CYCLES > 1) ? $clog2(LAYER_CYCLES) : 1;

  localparam logic [WIDTH_COL-1:0]   INFO_LAST  = WIDTH_COL'(NUM_INFO_COLS - 1);
  localparam logic [WIDTH_COL-1:0]   CODE_LAST  = WIDTH_COL'(NUM_CODE_COLS - 1);
  localparam logic [WIDTH_LAYER-1:0] LAYER_LAST = WIDTH_LAYER'(NUM_LAYERS - 1);
  localparam logic [WIDTH_CYC-1:0]   CYC_LAST   = WIDTH_CYC'(LAYER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_PARITY = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [WIDTH_COL-1:0]   col_q;
  logic [WIDTH_LAYER-1:0] layer_q;
  logic [WIDTH_CYC-1:0]   cyc_q;
  logic                   err_q;

  logic accept;
  logic info_final;
  logic frame_err;

  // Handshake and output decode from the registered state; readyIn is also
  // gated by reset so no write strobe can escape while the block is held.
  always_comb begin
    readyIn        = reset && (state_q == ST_LOAD) && (rate == RATE_1_2);
    accept         = validIn && readyIn;
    info_final     = (col_q == INFO_LAST);
    frame_err      = (lastIn != info_final);
    InfoWrEn       = accept;
    CurrCol        = col_q;
    CurrLayer      = (state_q == ST_PARITY) ? layer_q : '0;
    ParityAccValid = (state_q == ST_PARITY) && (cyc_q == '0);
    validOut       = (state_q == ST_OUTPUT);
    lastOut        = (state_q == ST_OUTPUT) && (col_q == CODE_LAST);
    busy           = (state_q != ST_LOAD) || (col_q != '0);
    errLast        = err_q;
  end

  // Sequencer: state, counters and the sticky framing flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      col_q   <= '0;
      layer_q <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            // Beat count alone frames the block; lastIn only feeds errLast.
            if (frame_err) begin
              err_q <= 1'b1;
            end else if (col_q == '0) begin
              err_q <= 1'b0;
            end
            if (info_final) begin
              col_q   <= '0;
              state_q <= ST_PARITY;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (layer_q == LAYER_LAST) begin
              layer_q <= '0;
              state_q <= ST_OUTPUT;
            end else begin
              layer_q <= layer_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (readyOut) begin
            if (col_q == CODE_LAST) begin
              col_q   <= '0;
              state_q <= ST_LOAD;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
          col_q   <= '0;
          layer_q <= '0;
          cyc_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_encoder_engine.sv
// Bench for fsm_encoder_engine: stimulus pushes the expected event stream of
// each block into a queue, a negedge monitor pops and compares DUT events.
module tb_fsm_encoder_engine;

  localparam int NL = 8;
  localparam int NI = 8;
  localparam int NC = 16;
  localparam int LC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rate = 2'd0;
  logic       validIn = 1'b0;
  logic       lastIn = 1'b0;
  logic       readyOut = 1'b1;
  logic       readyIn, InfoWrEn, ParityAccValid, validOut, lastOut, busy, errLast;
  logic [3:0] CurrCol;
  logic [2:0] CurrLayer;

  fsm_encoder_engine #(
    .NUM_LAYERS(NL), .NUM_INFO_COLS(NI), .NUM_CODE_COLS(NC), .LAYER_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .rate(rate), .validIn(validIn), .lastIn(lastIn),
    .readyIn(readyIn), .InfoWrEn(InfoWrEn), .CurrCol(CurrCol), .CurrLayer(CurrLayer),
    .ParityAccValid(ParityAccValid), .validOut(validOut), .lastOut(lastOut),
    .readyOut(readyOut), .busy(busy), .errLast(errLast)
  );

  always #5 clk = ~clk;

  // kind: 0 info write, 1 parity layer strobe, 2 codeword beat
  typedef struct {
    int kind;
    int idx;
    bit last;
    bit err;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  ev_t ev;
  int  cyc = 0;
  int  last_evt = 0;
  bit  err_model = 0;
  bit  prev_stall = 0;
  bit  prev_vo = 0;
  bit  prev_last = 0;
  bit  chk_idle = 0;
  int  prev_col = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      err_model  = 0;
      prev_stall = 0;
      prev_vo    = 0;
      chk_idle   = 0;
    end else begin
      check("errLast", errLast, err_model);
      if (chk_idle) begin
        check("idle_busy", busy, 0);
        chk_idle = 0;
      end
      if (prev_stall) begin
        check("hold_col", CurrCol, prev_col);
        check("hold_valid", validOut, 1);
        check("hold_last", lastOut, prev_last);
      end
      if (validOut && !prev_vo) check("out_latency", cyc - last_evt, LC);
      if (InfoWrEn) begin
        if (q.size() == 0) check("info_unexpected", InfoWrEn, 0);
        else begin
          ev = q.pop_front();
          check("info_kind", 0, ev.kind);
          check("info_col", CurrCol, ev.idx);
          err_model = ev.err;
          if (ev.idx == NI - 1) last_evt = cyc;
        end
      end
      if (ParityAccValid) begin
        if (q.size() == 0) check("parity_unexpected", ParityAccValid, 0);
        else begin
          ev = q.pop_front();
          check("parity_kind", 1, ev.kind);
          check("parity_layer", CurrLayer, ev.idx);
          check("parity_spacing", cyc - last_evt, (ev.idx == 0) ? 1 : LC);
          check("parity_busy", busy, 1);
          last_evt = cyc;
        end
      end
      if (validOut && readyOut) begin
        if (q.size() == 0) check("out_unexpected", validOut, 0);
        else begin
          ev = q.pop_front();
          check("out_kind", 2, ev.kind);
          check("out_col", CurrCol, ev.idx);
          check("out_last", lastOut, ev.last);
          if (ev.last) chk_idle = 1;
        end
      end
      prev_stall = validOut && !readyOut;
      prev_col   = CurrCol;
      prev_last  = lastOut;
      prev_vo    = validOut;
    end
  end

  // ---------------- stimulus ----------------
  bit tb_err = 0;

  task automatic check_all_zero(input string tag);
    check({tag, "_errLast"}, errLast, 0);
    check({tag, "_pav"}, ParityAccValid, 0);
    check({tag, "_validOut"}, validOut, 0);
    check({tag, "_lastOut"}, lastOut, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_InfoWrEn"}, InfoWrEn, 0);
    check({tag, "_CurrCol"}, CurrCol, 0);
    check({tag, "_CurrLayer"}, CurrLayer, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!readyIn && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", readyIn, 1);
  endtask

  // mask bit i = lastIn on beat i; rmode 0: readyOut=1, 1: 1,0,0,1 pattern,
  // 2: random; rst_layer >= 0 resets the engine when that layer strobes.
  task automatic run_block(input logic [7:0] mask, input int rmode,
                           input bit gaps, input int rst_layer);
    int k;
    bit mism;
    rate = 2'd0; validIn = 0; lastIn = 0; readyOut = 1;
    wait_ready();
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          rate = 2'($urandom_range(1, 3));
          validIn = 1'($urandom);
          lastIn = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      rate = 2'd0; validIn = 1; lastIn = mask[i];
      mism = (mask[i] != (i == NI - 1));
      tb_err = mism ? 1'b1 : ((i == 0) ? 1'b0 : tb_err);
      q.push_back('{0, i, 1'b0, tb_err});
      @(posedge clk); #1;
    end
    validIn = 0; lastIn = 0;
    for (int l = 0; l < NL; l++) q.push_back('{1, l, 1'b0, 1'b0});
    for (int c = 0; c < NC; c++) q.push_back('{2, c, (c == NC - 1), 1'b0});
    k = 0;
    while (q.size() != 0 && k < 400) begin
      if (rst_layer >= 0 && ParityAccValid && CurrLayer == 3'(rst_layer)) begin
        reset = 0; validIn = 0; #1;
        check_all_zero("rst_mid");
        q.delete();
        tb_err = 0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("rst_held");
        rate = 2'd0; readyOut = 1; reset = 1;
        return;
      end
      validIn = 1'($urandom);
      lastIn = 1'($urandom);
      rate = 2'($urandom);
      case (rmode)
        0: readyOut = 1;
        1: readyOut = ((k % 4) == 0) || ((k % 4) == 3);
        default: readyOut = 1'($urandom);
      endcase
      @(posedge clk); #1;
      k++;
    end
    check("block_timeout", q.size(), 0);
    validIn = 0; lastIn = 0; rate = 2'd0; readyOut = 1;
  endtask

  initial begin
    logic [7:0] m;
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 reset = 1;
    @(posedge clk); #1;
    check("post_reset_ready", readyIn, 1);
    check("post_reset_busy", busy, 0);

    // nominal, back-to-back
    run_block(8'h80, 0, 0, -1);
    // backpressure pattern
    run_block(8'h80, 1, 0, -1);
    // framing error then a clean block
    run_block(8'h08, 0, 0, -1);
    run_block(8'h80, 0, 0, -1);

    // unsupported rates never accept
    validIn = 1;
    repeat (10) begin
      rate = 2'($urandom_range(1, 3));
      #1;
      check("badrate_ready", readyIn, 0);
      check("badrate_wren", InfoWrEn, 0);
      check("badrate_busy", busy, 0);
      @(posedge clk); #1;
    end
    validIn = 0; rate = 2'd0;

    // reset in PARITY at layer 4, then a normal block
    run_block(8'h80, 2, 1, 4);
    run_block(8'h80, 0, 0, -1);

    // random blocks
    repeat (10) begin
      m = (($urandom % 4) == 0) ? 8'($urandom) : 8'h80;
      run_block(m, 2, 1, -1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
